// File: rtl/fb_bank_scheduler.sv
// Triple-buffer bank scheduler for the shared 320x240 frame store.
// Rotates display/write/ready banks so the writer always has a free bank and
// the display only changes at the vsync falling edge, so it never tears.
module fb_bank_scheduler #(
  parameter int FRAME_WORDS = 76800,
  parameter int ADDR_W      = 18,
  parameter int CNT_W       = 8
) (
  input  logic              clk25,
  input  logic              resetn,
  input  logic              wr_frame_start,
  input  logic              wr_frame_done,
  input  logic              vga_vsync,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              wr_active,
  output logic              frame_pending,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic [CNT_W-1:0]  frames_aborted
);

  typedef enum logic {IDLE, WRITING} wr_state_t;

  wr_state_t   state, state_n;
  logic [1:0]  rdy_bank;
  logic [1:0]  rd_bank_n, wr_bank_n, rdy_bank_n;
  logic        pending_n;
  logic        vsync_q;
  logic        commit, abort, swap;

  // Base address lookup from constants; the bank index never exceeds 2.
  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] b);
    case (b)
      2'd0:    base_of = '0;
      2'd1:    base_of = ADDR_W'(FRAME_WORDS);
      default: base_of = ADDR_W'(2 * FRAME_WORDS);
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  assign commit    = (state == WRITING) && wr_frame_done;
  assign abort     = (state == WRITING) && wr_frame_start && !wr_frame_done;
  assign swap      = vsync_q && !vga_vsync;
  assign wr_active = (state == WRITING);

  // Writer FSM next state: a done in IDLE is ignored; start+done while
  // writing commits and immediately opens the next frame.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (wr_frame_start) state_n = WRITING;
      WRITING: if (wr_frame_done)  state_n = wr_frame_start ? WRITING : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bank rotation: commit+swap sends the fresh frame straight to display,
  // leaving the ready bank untouched.
  always_comb begin
    rd_bank_n  = rd_bank;
    wr_bank_n  = wr_bank;
    rdy_bank_n = rdy_bank;
    pending_n  = frame_pending;
    if (commit && swap) begin
      rd_bank_n = wr_bank;
      wr_bank_n = rd_bank;
      pending_n = 1'b0;
    end else if (commit) begin
      rdy_bank_n = wr_bank;
      wr_bank_n  = rdy_bank;
      pending_n  = 1'b1;
    end else if (swap && frame_pending) begin
      rd_bank_n  = rdy_bank;
      rdy_bank_n = rd_bank;
      pending_n  = 1'b0;
    end
  end

  // FSM state and vsync history register.
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      vsync_q <= 1'b1;
    end else begin
      state   <= state_n;
      vsync_q <= vga_vsync;
    end
  end

  // Bank fields and their bases load on the same edge so they never disagree.
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      rd_bank       <= 2'd0;
      wr_bank       <= 2'd1;
      rdy_bank      <= 2'd2;
      rd_base       <= '0;
      wr_base       <= ADDR_W'(FRAME_WORDS);
      frame_pending <= 1'b0;
    end else begin
      rd_bank       <= rd_bank_n;
      wr_bank       <= wr_bank_n;
      rdy_bank      <= rdy_bank_n;
      rd_base       <= base_of(rd_bank_n);
      wr_base       <= base_of(wr_bank_n);
      frame_pending <= pending_n;
    end
  end

  // Saturating drop and abort counters.
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      frames_dropped <= '0;
      frames_aborted <= '0;
    end else begin
      if (commit && frame_pending) frames_dropped <= sat_inc(frames_dropped);
      if (abort)                   frames_aborted <= sat_inc(frames_aborted);
    end
  end

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Directed bench for fb_bank_scheduler: one task per scenario, inline checks.
module tb_fb_bank_scheduler;

  localparam int FW = 76800;

  logic        clk25 = 1'b0;
  logic        resetn;
  logic        wr_frame_start, wr_frame_done, vga_vsync;
  logic [1:0]  wr_bank, rd_bank;
  logic [17:0] wr_base, rd_base;
  logic        wr_active, frame_pending;
  logic [7:0]  frames_dropped, frames_aborted;

  int n_cmp = 0;
  int n_bad = 0;

  fb_bank_scheduler #(.FRAME_WORDS(FW), .ADDR_W(18), .CNT_W(8)) dut (
    .clk25(clk25), .resetn(resetn),
    .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
    .vga_vsync(vga_vsync),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_base(wr_base), .rd_base(rd_base),
    .wr_active(wr_active), .frame_pending(frame_pending),
    .frames_dropped(frames_dropped), .frames_aborted(frames_aborted)
  );

  always #20 clk25 = ~clk25;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk25); #1;
    resetn = 1'b0; wr_frame_start = 1'b0; wr_frame_done = 1'b0; vga_vsync = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic frame();
    wr_frame_start = 1'b1; tick(); wr_frame_start = 1'b0;
    wr_frame_done  = 1'b1; tick(); wr_frame_done  = 1'b0;
  endtask

  task automatic vsync_edge();
    vga_vsync = 1'b0; tick();
    vga_vsync = 1'b1; tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rd_bank !== 2'd0) begin n_bad++; $display("FAIL reset_rd_bank got %0d want 0", rd_bank); end
    n_cmp++; if (wr_bank !== 2'd1) begin n_bad++; $display("FAIL reset_wr_bank got %0d want 1", wr_bank); end
    n_cmp++; if (rd_base !== 18'd0) begin n_bad++; $display("FAIL reset_rd_base got %0d want 0", rd_base); end
    n_cmp++; if (wr_base !== 18'(FW)) begin n_bad++; $display("FAIL reset_wr_base got %0d want %0d", wr_base, FW); end
    n_cmp++; if (wr_active !== 1'b0 || frame_pending !== 1'b0) begin n_bad++; $display("FAIL reset_flags got act=%0b pend=%0b want 0 0", wr_active, frame_pending); end
    n_cmp++; if (frames_dropped !== 8'd0 || frames_aborted !== 8'd0) begin n_bad++; $display("FAIL reset_counters got %0d/%0d want 0/0", frames_dropped, frames_aborted); end
  endtask

  task automatic test_idle_swap();
    do_reset();
    vsync_edge();
    n_cmp++; if (rd_bank !== 2'd0 || rd_base !== 18'd0) begin n_bad++; $display("FAIL idle_swap_rd got bank=%0d base=%0d want 0 0", rd_bank, rd_base); end
    n_cmp++; if (frame_pending !== 1'b0) begin n_bad++; $display("FAIL idle_swap_pending got %0b want 0", frame_pending); end
  endtask

  task automatic test_single_frame();
    do_reset();
    wr_frame_start = 1'b1; tick(); wr_frame_start = 1'b0;
    n_cmp++; if (wr_active !== 1'b1) begin n_bad++; $display("FAIL single_active got %0b want 1", wr_active); end
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    n_cmp++; if (wr_bank !== 2'd2 || wr_base !== 18'd153600) begin n_bad++; $display("FAIL single_commit_wr got bank=%0d base=%0d want 2 153600", wr_bank, wr_base); end
    n_cmp++; if (frame_pending !== 1'b1 || wr_active !== 1'b0) begin n_bad++; $display("FAIL single_commit_flags got pend=%0b act=%0b want 1 0", frame_pending, wr_active); end
    // vsync held low: one swap, then a frame committed while still low must not swap again
    vga_vsync = 1'b0; tick();
    n_cmp++; if (rd_bank !== 2'd1 || rd_base !== 18'(FW) || frame_pending !== 1'b0) begin n_bad++; $display("FAIL single_swap got rd=%0d base=%0d pend=%0b want 1 76800 0", rd_bank, rd_base, frame_pending); end
    frame(); tick(); tick();
    n_cmp++; if (rd_bank !== 2'd1 || frame_pending !== 1'b1 || wr_bank !== 2'd0) begin n_bad++; $display("FAIL held_low_no_swap got rd=%0d pend=%0b wr=%0d want 1 1 0", rd_bank, frame_pending, wr_bank); end
    vga_vsync = 1'b1; tick();
    vga_vsync = 1'b0; tick();
    n_cmp++; if (rd_bank !== 2'd2 || rd_base !== 18'd153600 || frame_pending !== 1'b0) begin n_bad++; $display("FAIL second_swap got rd=%0d base=%0d pend=%0b want 2 153600 0", rd_bank, rd_base, frame_pending); end
    vga_vsync = 1'b1; tick();
  endtask

  task automatic test_drops();
    do_reset();
    frame(); frame(); frame();
    n_cmp++; if (frames_dropped !== 8'd2) begin n_bad++; $display("FAIL drops_count got %0d want 2", frames_dropped); end
    n_cmp++; if (frame_pending !== 1'b1) begin n_bad++; $display("FAIL drops_pending got %0b want 1", frame_pending); end
    n_cmp++; if (rd_bank !== 2'd0 || wr_bank !== 2'd2 || wr_base !== 18'd153600) begin n_bad++; $display("FAIL drops_banks got rd=%0d wr=%0d base=%0d want 0 2 153600", rd_bank, wr_bank, wr_base); end
    vsync_edge();
    n_cmp++; if (rd_bank !== 2'd1 || wr_bank !== 2'd2) begin n_bad++; $display("FAIL drops_perm got rd=%0d wr=%0d want 1 2", rd_bank, wr_bank); end
  endtask

  task automatic test_abort();
    do_reset();
    wr_frame_start = 1'b1; tick(); tick(); wr_frame_start = 1'b0;
    n_cmp++; if (frames_aborted !== 8'd1 || wr_bank !== 2'd1 || wr_active !== 1'b1) begin n_bad++; $display("FAIL abort_state got ab=%0d wr=%0d act=%0b want 1 1 1", frames_aborted, wr_bank, wr_active); end
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    n_cmp++; if (wr_bank !== 2'd2 || frame_pending !== 1'b1 || frames_dropped !== 8'd0) begin n_bad++; $display("FAIL abort_commit got wr=%0d pend=%0b drop=%0d want 2 1 0", wr_bank, frame_pending, frames_dropped); end
    vsync_edge();
    n_cmp++; if (rd_bank !== 2'd1 || rd_base !== 18'(FW)) begin n_bad++; $display("FAIL abort_display got rd=%0d base=%0d want 1 76800", rd_bank, rd_base); end
  endtask

  task automatic test_commit_swap();
    do_reset();
    frame();
    wr_frame_start = 1'b1; tick(); wr_frame_start = 1'b0;
    wr_frame_done = 1'b1; vga_vsync = 1'b0; tick(); wr_frame_done = 1'b0;
    n_cmp++; if (rd_bank !== 2'd2 || rd_base !== 18'd153600) begin n_bad++; $display("FAIL cs_rd got bank=%0d base=%0d want 2 153600", rd_bank, rd_base); end
    n_cmp++; if (wr_bank !== 2'd0 || wr_base !== 18'd0) begin n_bad++; $display("FAIL cs_wr got bank=%0d base=%0d want 0 0", wr_bank, wr_base); end
    n_cmp++; if (frames_dropped !== 8'd1 || frame_pending !== 1'b0) begin n_bad++; $display("FAIL cs_flags got drop=%0d pend=%0b want 1 0", frames_dropped, frame_pending); end
    vga_vsync = 1'b1; tick();
  endtask

  task automatic test_back_to_back_saturate();
    do_reset();
    wr_frame_start = 1'b1; tick();
    wr_frame_done = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    wr_frame_start = 1'b0; wr_frame_done = 1'b0;
    n_cmp++; if (frames_dropped !== 8'd255) begin n_bad++; $display("FAIL sat_dropped got %0d want 255", frames_dropped); end
    n_cmp++; if (frames_aborted !== 8'd0 || frame_pending !== 1'b1 || wr_active !== 1'b1) begin n_bad++; $display("FAIL b2b_flags got ab=%0d pend=%0b act=%0b want 0 1 1", frames_aborted, frame_pending, wr_active); end
    // asynchronous reset mid-cycle, away from any clock edge
    #5 resetn = 1'b0;
    #1;
    n_cmp++; if (frames_dropped !== 8'd0 || frames_aborted !== 8'd0 || wr_active !== 1'b0 || frame_pending !== 1'b0) begin n_bad++; $display("FAIL async_reset_flags got drop=%0d ab=%0d act=%0b pend=%0b want 0 0 0 0", frames_dropped, frames_aborted, wr_active, frame_pending); end
    n_cmp++; if (rd_bank !== 2'd0 || wr_bank !== 2'd1 || rd_base !== 18'd0 || wr_base !== 18'(FW)) begin n_bad++; $display("FAIL async_reset_banks got rd=%0d wr=%0d rb=%0d wb=%0d want 0 1 0 76800", rd_bank, wr_bank, rd_base, wr_base); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b1; wr_frame_start = 1'b0; wr_frame_done = 1'b0; vga_vsync = 1'b1;
    test_reset();
    test_idle_swap();
    test_single_frame();
    test_drops();
    test_abort();
    test_commit_swap();
    test_back_to_back_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
